// File: rtl/cfr_cpw_sequencer.sv
// Gates the peak-cancellation stage off, drains, then copies len I/Q pairs from the source RAM into the CPW table.
// Write latency is one cycle after each read; no backpressure: the copy runs one coefficient per cycle once started.
module cfr_cpw_sequencer #(
  parameter int CPW_ADDR_WIDTH = 8,
  parameter int CPW_DATA_WIDTH = 16,
  parameter int DRAIN_CYCLES   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_start,
  input  logic                      cmd_abort,
  input  logic [CPW_ADDR_WIDTH:0]   cmd_len,
  input  logic                      user_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  output logic                      err,
  output logic                      ctrl_enable,
  output logic                      src_rd_en,
  output logic [CPW_ADDR_WIDTH-1:0] src_rd_addr,
  input  logic [CPW_DATA_WIDTH-1:0] src_rd_data_i,
  input  logic [CPW_DATA_WIDTH-1:0] src_rd_data_q,
  output logic                      cpw_wr_en,
  output logic [CPW_ADDR_WIDTH-1:0] cpw_wr_addr,
  output logic [CPW_DATA_WIDTH-1:0] cpw_wr_data_i,
  output logic [CPW_DATA_WIDTH-1:0] cpw_wr_data_q
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int RW  = CPW_ADDR_WIDTH + 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);
  localparam logic [RW-1:0]  DEPTH      = {1'b1, {CPW_ADDR_WIDTH{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    LOAD  = 3'd2,
    FLUSH = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t         state;
  logic [RW-1:0]  len_q;
  logic [RW-1:0]  rd_cnt;
  logic [DCW-1:0] drain_cnt;
  logic           abort_q;
  logic           len_ok;

  assign len_ok = (cmd_len != '0) && (cmd_len <= DEPTH);

  // The source RAM output register is the data flop; gating keeps the bus quiet between writes.
  assign cpw_wr_data_i = cpw_wr_en ? src_rd_data_i : '0;
  assign cpw_wr_data_q = cpw_wr_en ? src_rd_data_q : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      rd_cnt      <= '0;
      drain_cnt   <= '0;
      abort_q     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
      ctrl_enable <= 1'b0;
      src_rd_en   <= 1'b0;
      src_rd_addr <= '0;
      cpw_wr_en   <= 1'b0;
      cpw_wr_addr <= '0;
    end else begin
      done        <= 1'b0;
      aborted     <= 1'b0;
      err         <= 1'b0;
      cpw_wr_en   <= src_rd_en;
      cpw_wr_addr <= src_rd_addr;

      unique case (state)
        IDLE: begin
          ctrl_enable <= user_enable;
          if (cmd_start) begin
            if (len_ok) begin
              state       <= DRAIN;
              len_q       <= cmd_len;
              drain_cnt   <= '0;
              rd_cnt      <= '0;
              abort_q     <= 1'b0;
              busy        <= 1'b1;
              ctrl_enable <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end

        DRAIN: begin
          ctrl_enable <= 1'b0;
          err         <= cmd_start;
          if (cmd_abort) begin
            state   <= FLUSH;
            abort_q <= 1'b1;
          end else if (drain_cnt == DRAIN_LAST) begin
            state       <= LOAD;
            src_rd_en   <= 1'b1;
            src_rd_addr <= '0;
            rd_cnt      <= RW'(1);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        LOAD: begin
          ctrl_enable <= 1'b0;
          err         <= cmd_start;
          // rd_cnt counts reads already issued; it is one bit wider so len == depth terminates cleanly.
          if (cmd_abort || (rd_cnt == len_q)) begin
            state       <= FLUSH;
            abort_q     <= cmd_abort;
            src_rd_en   <= 1'b0;
            src_rd_addr <= '0;
          end else begin
            src_rd_addr <= rd_cnt[CPW_ADDR_WIDTH-1:0];
            rd_cnt      <= rd_cnt + 1'b1;
          end
        end

        FLUSH: begin
          err         <= cmd_start;
          state       <= FIN;
          done        <= 1'b1;
          aborted     <= abort_q;
          busy        <= 1'b0;
          ctrl_enable <= user_enable;
        end

        FIN: begin
          err         <= cmd_start;
          state       <= IDLE;
          ctrl_enable <= user_enable;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
